// File: rtl/nx_mesh_io.sv
// nx_mesh_io: host <-> mesh edge adapter.
//
// Inbound path: host messages are steered by their destination-column field
// into a one-entry injection slot per column. These slots feed the top row of the mesh.
// A message whose column is out of range is consumed and discarded, and the
// sticky drop flag is set.
//
// Outbound path: each column's bottom-row egress fills a small FIFO. A
// round-robin arbiter drains the FIFOs into a single output register, which
// drives the host outbound stream.
//
// Idle: a registered, filtered flag. It rises after IDLE_CYCLES consecutive
// quiet cycles. Quiet means all nodes are idle, nothing is buffered anywhere and
// no inbound offer is pending.
//
// Handshake rule for every stream: a beat transfers on a cycle where valid
// and ready are both high. A producer holding valid keeps its data stable
// until the beat is accepted. Readys never depend on the same-stream valid.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-low reset
//   trigger_i                          mesh cycle trigger (restarts idle filter)
//   node_idle_i[COLUMNS]               per-column aggregated node idle
//   idle_o                             filtered mesh+edge idle
//   drop_o                             sticky out-of-range-column discard flag
//   ib_data_i/ib_valid_i/ib_ready_o    host inbound stream
//   mesh_ib_*                          per-column top-row injection streams
//   mesh_ob_*                          per-column bottom-row egress streams
//   ob_data_o/ob_valid_o/ob_ready_i    host outbound stream
module nx_mesh_io #(
    parameter int COLUMNS        = 3,
    parameter int MSG_WIDTH      = 32,
    parameter int COL_LSB        = 16,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int IDLE_CYCLES    = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           trigger_i,
    input  logic [COLUMNS-1:0]             node_idle_i,
    output logic                           idle_o,
    output logic                           drop_o,
    input  logic [MSG_WIDTH-1:0]           ib_data_i,
    input  logic                           ib_valid_i,
    output logic                           ib_ready_o,
    output logic [COLUMNS*MSG_WIDTH-1:0]   mesh_ib_data_o,
    output logic [COLUMNS-1:0]             mesh_ib_valid_o,
    input  logic [COLUMNS-1:0]             mesh_ib_ready_i,
    input  logic [COLUMNS*MSG_WIDTH-1:0]   mesh_ob_data_i,
    input  logic [COLUMNS-1:0]             mesh_ob_valid_i,
    output logic [COLUMNS-1:0]             mesh_ob_ready_o,
    output logic [MSG_WIDTH-1:0]           ob_data_o,
    output logic                           ob_valid_o,
    input  logic                           ob_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int RR_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [ADDR_COL_WIDTH:0] COLS_LIM = (ADDR_COL_WIDTH + 1)'(COLUMNS);
    localparam logic [CNT_W-1:0]        IDLE_MAX = CNT_W'(IDLE_CYCLES);

    // ---------------------------------------------------------------- state
    // r_run is low during reset and rises on the first edge after release.
    // It gates every ready so that no ready is high while reset is asserted.
    logic                  r_run;
    logic [COLUMNS-1:0]    r_slot_valid;
    logic [MSG_WIDTH-1:0]  r_slot_data [COLUMNS];
    logic [MSG_WIDTH-1:0]  r_fifo_mem  [COLUMNS][FIFO_DEPTH];
    logic [PTR_W:0]        r_wr_ptr    [COLUMNS];
    logic [PTR_W:0]        r_rd_ptr    [COLUMNS];
    logic                  r_ob_valid;
    logic [MSG_WIDTH-1:0]  r_ob_data;
    logic [RR_W-1:0]       r_rr;
    logic [CNT_W-1:0]      r_quiet_cnt;
    logic                  r_idle;
    logic                  r_drop;

    // ---------------------------------------------------------------- inbound
    logic [ADDR_COL_WIDTH-1:0] w_dest;
    logic                      w_in_range;
    logic [COLUMNS-1:0]        w_dest_sel;
    logic [COLUMNS-1:0]        w_slot_free;
    logic [COLUMNS-1:0]        w_slot_load;
    logic [COLUMNS-1:0]        w_slot_drain;
    logic                      w_ib_ready;
    logic                      w_ib_fire;
    logic                      w_drop_fire;

    assign w_dest     = ib_data_i[COL_LSB +: ADDR_COL_WIDTH];
    assign w_in_range = {1'b0, w_dest} < COLS_LIM;

    // ---------------------------------------------------------------- outbound
    logic [COLUMNS-1:0]    w_fifo_empty;
    logic [COLUMNS-1:0]    w_fifo_full;
    logic [COLUMNS-1:0]    w_push;
    logic [COLUMNS-1:0]    w_pop;
    logic [COLUMNS-1:0]    w_ob_ready;
    logic                  w_load;
    logic                  w_grant_valid;
    logic [COLUMNS-1:0]    w_grant_sel;
    logic [MSG_WIDTH-1:0]  w_grant_data;
    logic [RR_W-1:0]       w_rr_next;
    int                    w_idx;
    logic                  w_quiet;

    for (genvar c = 0; c < COLUMNS; c++) begin : g_col
        assign w_dest_sel[c]   = w_in_range && (w_dest == ADDR_COL_WIDTH'(c));
        // A full slot also counts as free when it drains this cycle,
        // so one slot can carry one message per cycle.
        assign w_slot_free[c]  = !r_slot_valid[c] || mesh_ib_ready_i[c];
        assign w_slot_load[c]  = w_ib_fire && w_dest_sel[c];
        assign w_slot_drain[c] = r_slot_valid[c] && mesh_ib_ready_i[c];

        assign w_fifo_empty[c] = (r_wr_ptr[c] == r_rd_ptr[c]);
        assign w_fifo_full[c]  = (r_wr_ptr[c][PTR_W] != r_rd_ptr[c][PTR_W]) &&
                                 (r_wr_ptr[c][PTR_W-1:0] == r_rd_ptr[c][PTR_W-1:0]);
        // Readiness is derived from fullness alone. A full FIFO therefore refuses a
        // push even when it is being popped in the same cycle.
        assign w_ob_ready[c]   = r_run && !w_fifo_full[c];
        assign w_push[c]       = mesh_ob_valid_i[c] && w_ob_ready[c];
        assign w_pop[c]        = w_load && w_grant_valid && w_grant_sel[c];

        assign mesh_ib_data_o[c*MSG_WIDTH +: MSG_WIDTH] = r_slot_data[c];
    end

    assign w_ib_ready  = r_run && (w_in_range ? |(w_dest_sel & w_slot_free) : 1'b1);
    assign w_ib_fire   = ib_valid_i && w_ib_ready;
    assign w_drop_fire = w_ib_fire && !w_in_range;

    // The output register loads when it is empty, or when its current contents
    // are being taken by the host in this cycle.
    assign w_load = !r_ob_valid || ob_ready_i;

    // Round-robin pick: the first non-empty FIFO at or after r_rr, with wrap-around.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_sel   = '0;
        w_grant_data  = '0;
        w_rr_next     = r_rr;
        w_idx         = 0;
        for (int i = 0; i < COLUMNS; i++) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= COLUMNS) begin
                w_idx = w_idx - COLUMNS;
            end
            if (!w_grant_valid && !w_fifo_empty[w_idx]) begin
                w_grant_valid       = 1'b1;
                w_grant_sel[w_idx]  = 1'b1;
                w_grant_data        = r_fifo_mem[w_idx][r_rd_ptr[w_idx][PTR_W-1:0]];
                w_rr_next           = (w_idx == COLUMNS - 1) ? '0 : RR_W'(w_idx + 1);
            end
        end
    end

    assign w_quiet = (&node_idle_i) && !(|r_slot_valid) && (&w_fifo_empty) &&
                     !r_ob_valid && !ib_valid_i;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_run        <= 1'b0;
            r_slot_valid <= '0;
            r_ob_valid   <= 1'b0;
            r_ob_data    <= '0;
            r_rr         <= '0;
            r_quiet_cnt  <= '0;
            r_idle       <= 1'b0;
            r_drop       <= 1'b0;
            for (int c = 0; c < COLUMNS; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
            end
        end else begin
            r_run <= 1'b1;

            for (int c = 0; c < COLUMNS; c++) begin
                if (w_slot_load[c]) begin
                    r_slot_valid[c] <= 1'b1;
                end else if (w_slot_drain[c]) begin
                    r_slot_valid[c] <= 1'b0;
                end
                if (w_push[c]) begin
                    r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                end
                if (w_pop[c]) begin
                    r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                end
            end

            if (w_drop_fire) begin
                r_drop <= 1'b1;
            end

            if (w_load) begin
                r_ob_valid <= w_grant_valid;
                if (w_grant_valid) begin
                    r_ob_data <= w_grant_data;
                    r_rr      <= w_rr_next;
                end
            end

            // The trigger restarts only the idle filter. It never touches the datapath.
            if (trigger_i || !w_quiet) begin
                r_quiet_cnt <= '0;
            end else if (r_quiet_cnt != IDLE_MAX) begin
                r_quiet_cnt <= r_quiet_cnt + 1'b1;
            end
            r_idle <= w_quiet && !trigger_i && (r_quiet_cnt == IDLE_MAX);
        end
    end

    // Payload storage carries no reset. Occupancy is tracked by the valid bits
    // and pointers above, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < COLUMNS; c++) begin
            if (w_slot_load[c]) begin
                r_slot_data[c] <= ib_data_i;
            end
            if (w_push[c]) begin
                r_fifo_mem[c][r_wr_ptr[c][PTR_W-1:0]] <= mesh_ob_data_i[c*MSG_WIDTH +: MSG_WIDTH];
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign ib_ready_o      = w_ib_ready;
    assign mesh_ib_valid_o = r_slot_valid;
    assign mesh_ob_ready_o = w_ob_ready;
    assign ob_data_o       = r_ob_data;
    assign ob_valid_o      = r_ob_valid;
    assign idle_o          = r_idle;
    assign drop_o          = r_drop;

endmodule

// File: tb/tb_nx_mesh_io.sv
module tb_nx_mesh_io;

  localparam int COLS = 3;
  localparam int W    = 32;

  logic              clk;
  logic              rst_i;
  logic              trigger_i;
  logic [COLS-1:0]   node_idle_i;
  logic              idle_o;
  logic              drop_o;
  logic [W-1:0]      ib_data_i;
  logic              ib_valid_i;
  logic              ib_ready_o;
  logic [COLS*W-1:0] mesh_ib_data_o;
  logic [COLS-1:0]   mesh_ib_valid_o;
  logic [COLS-1:0]   mesh_ib_ready_i;
  logic [COLS*W-1:0] mesh_ob_data_i;
  logic [COLS-1:0]   mesh_ob_valid_i;
  logic [COLS-1:0]   mesh_ob_ready_o;
  logic [W-1:0]      ob_data_o;
  logic              ob_valid_o;
  logic              ob_ready_i;

  nx_mesh_io dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .trigger_i       (trigger_i),
    .node_idle_i     (node_idle_i),
    .idle_o          (idle_o),
    .drop_o          (drop_o),
    .ib_data_i       (ib_data_i),
    .ib_valid_i      (ib_valid_i),
    .ib_ready_o      (ib_ready_o),
    .mesh_ib_data_o  (mesh_ib_data_o),
    .mesh_ib_valid_o (mesh_ib_valid_o),
    .mesh_ib_ready_i (mesh_ib_ready_i),
    .mesh_ob_data_i  (mesh_ob_data_i),
    .mesh_ob_valid_i (mesh_ob_valid_i),
    .mesh_ob_ready_o (mesh_ob_ready_o),
    .ob_data_o       (ob_data_o),
    .ob_valid_o      (ob_valid_o),
    .ob_ready_i      (ob_ready_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  typedef struct {
    logic [W-1:0]    msg;
    logic [COLS-1:0] exp_mask;
    logic            exp_drop;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name);
    exp_v = exp_q.pop_front();
    check({name, "_valid"}, 64'(ob_valid_o), 64'd1);
    check({name, "_data"},  64'(ob_data_o),  64'(exp_v));
  endtask

  initial begin
    // Table: routing and discard. mesh_ib_ready_i stays high, so each slot drains on the following edge.
    vecs[0] = '{msg: 32'h0000_1234, exp_mask: 3'b001, exp_drop: 1'b0};
    vecs[1] = '{msg: 32'hABC1_0055, exp_mask: 3'b010, exp_drop: 1'b0};
    vecs[2] = '{msg: 32'h0002_BEEF, exp_mask: 3'b100, exp_drop: 1'b0};
    vecs[3] = '{msg: 32'h00F2_0001, exp_mask: 3'b100, exp_drop: 1'b0};
    vecs[4] = '{msg: 32'h0003_0000, exp_mask: 3'b000, exp_drop: 1'b1};
    vecs[5] = '{msg: 32'hFFFF_FFFF, exp_mask: 3'b000, exp_drop: 1'b1};

    rst_i           = 1'b0;
    trigger_i       = 1'b0;
    node_idle_i     = 3'b111;
    ib_data_i       = '0;
    ib_valid_i      = 1'b0;
    mesh_ib_ready_i = '0;
    mesh_ob_data_i  = '0;
    mesh_ob_valid_i = '0;
    ob_ready_i      = 1'b0;

    // ---------------- reset state
    #23;
    check("rst_ib_ready",   64'(ib_ready_o),      64'd0);
    check("rst_mob_ready",  64'(mesh_ob_ready_o), 64'd0);
    check("rst_ob_valid",   64'(ob_valid_o),      64'd0);
    check("rst_mib_valid",  64'(mesh_ib_valid_o), 64'd0);
    check("rst_idle",       64'(idle_o),          64'd0);
    check("rst_drop",       64'(drop_o),          64'd0);

    // ---------------- idle filter after release, then trigger
    step();
    rst_i = 1'b1;
    step();                                  // edge 1 after release
    check("rel_ib_ready",  64'(ib_ready_o),      64'd1);
    check("rel_mob_ready", 64'(mesh_ob_ready_o), 64'h7);
    check("idle_e1", 64'(idle_o), 64'd0);
    step(); step(); step();                  // edges 2..4
    check("idle_e4", 64'(idle_o), 64'd0);
    step();                                  // edge 5
    check("idle_e5", 64'(idle_o), 64'd1);
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    check("idle_trig", 64'(idle_o), 64'd0);
    step(); step(); step(); step();
    check("idle_trig4", 64'(idle_o), 64'd0);
    step();
    check("idle_trig5", 64'(idle_o), 64'd1);

    // ---------------- injection stall / drain-refill / independent slots
    mesh_ib_ready_i = 3'b000;
    ib_data_i = 32'h0002_0011; ib_valid_i = 1'b1;
    #1 check("inj_a_ready", 64'(ib_ready_o), 64'd1);
    step();
    check("inj_a_valid", 64'(mesh_ib_valid_o), 64'h4);
    check("inj_a_data",  64'(mesh_ib_data_o[2*W +: W]), 64'h0002_0011);
    check("idle_busy",   64'(idle_o), 64'd0);
    ib_data_i = 32'h0002_0022;
    #1 check("inj_b_stall", 64'(ib_ready_o), 64'd0);
    step();
    check("inj_b_hold_valid", 64'(mesh_ib_valid_o), 64'h4);
    check("inj_b_hold_data",  64'(mesh_ib_data_o[2*W +: W]), 64'h0002_0011);
    mesh_ib_ready_i = 3'b100;
    #1 check("inj_b_refill_ready", 64'(ib_ready_o), 64'd1);
    step();
    check("inj_b_valid", 64'(mesh_ib_valid_o), 64'h4);
    check("inj_b_data",  64'(mesh_ib_data_o[2*W +: W]), 64'h0002_0022);
    mesh_ib_ready_i = 3'b000;
    ib_data_i = 32'h0000_0033;
    #1 check("inj_c_ready", 64'(ib_ready_o), 64'd1);
    step();
    check("inj_c_valid", 64'(mesh_ib_valid_o), 64'h5);
    check("inj_c_data",  64'(mesh_ib_data_o[0 +: W]), 64'h0000_0033);
    ib_valid_i = 1'b0;
    mesh_ib_ready_i = 3'b111;
    step();
    check("inj_drained", 64'(mesh_ib_valid_o), 64'h0);

    // ---------------- table-driven routing / drop
    for (int v = 0; v < 6; v++) begin
      ib_data_i = vecs[v].msg; ib_valid_i = 1'b1;
      #1 check($sformatf("vec%0d_ready", v), 64'(ib_ready_o), 64'd1);
      step();
      ib_valid_i = 1'b0;
      check($sformatf("vec%0d_mask", v), 64'(mesh_ib_valid_o), 64'(vecs[v].exp_mask));
      for (int c = 0; c < COLS; c++) begin
        if (vecs[v].exp_mask[c])
          check($sformatf("vec%0d_data", v), 64'(mesh_ib_data_o[c*W +: W]), 64'(vecs[v].msg));
      end
      check($sformatf("vec%0d_drop", v), 64'(drop_o), 64'(vecs[v].exp_drop));
      step();
    end
    check("drop_held", 64'(drop_o), 64'd1);

    // ---------------- column 1 FIFO fill and ordered drain
    // The first message moves on into the output register, so four more
    // are needed before the FIFO itself is full.
    ob_ready_i = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      mesh_ob_valid_i = 3'b010;
      mesh_ob_data_i[1*W +: W] = 32'h1100_0000 + 32'(k);
      exp_q.push_back(32'h1100_0000 + 32'(k));
      #1 check($sformatf("fill%0d_ready", k), 64'(mesh_ob_ready_o[1]), 64'd1);
      step();
      if (k == 0) check("lat_e1_valid", 64'(ob_valid_o), 64'd0);
      if (k == 1) check("lat_e2_valid", 64'(ob_valid_o), 64'd1);
    end
    mesh_ob_data_i[1*W +: W] = 32'hDEAD_BEEF;
    #1 check("full_ready", 64'(mesh_ob_ready_o), 64'h5);
    step();
    check("full_ready_hold", 64'(mesh_ob_ready_o), 64'h5);
    mesh_ob_valid_i = '0;
    ob_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 check_out($sformatf("drain%0d", k));
      step();
    end
    check("drain_empty", 64'(ob_valid_o), 64'd0);
    check("drain_ready", 64'(mesh_ob_ready_o), 64'h7);

    // ---------------- reset with messages buffered
    ob_ready_i = 1'b0;
    mesh_ib_ready_i = 3'b000;
    for (int k = 0; k < 3; k++) begin
      mesh_ob_valid_i = 3'b100;
      mesh_ob_data_i[2*W +: W] = 32'h2200_0000 + 32'(k);
      step();
    end
    mesh_ob_valid_i = '0;
    ib_data_i = 32'h0001_0077; ib_valid_i = 1'b1;
    step();
    ib_valid_i = 1'b0;
    check("pre_rst_ob_valid",  64'(ob_valid_o),      64'd1);
    check("pre_rst_mib_valid", 64'(mesh_ib_valid_o), 64'h2);
    rst_i = 1'b0;
    #1;
    check("mid_rst_ob_valid",  64'(ob_valid_o),      64'd0);
    check("mid_rst_mib_valid", 64'(mesh_ib_valid_o), 64'h0);
    check("mid_rst_ib_ready",  64'(ib_ready_o),      64'd0);
    check("mid_rst_mob_ready", 64'(mesh_ob_ready_o), 64'h0);
    check("mid_rst_drop",      64'(drop_o),          64'd0);
    step(); step();
    rst_i = 1'b1;
    ob_ready_i = 1'b1;
    mesh_ib_ready_i = 3'b111;
    step();
    check("rel2_ib_ready",  64'(ib_ready_o),      64'd1);
    check("rel2_mob_ready", 64'(mesh_ob_ready_o), 64'h7);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stale%0d_ob", k),  64'(ob_valid_o),      64'd0);
      check($sformatf("stale%0d_mib", k), 64'(mesh_ib_valid_o), 64'h0);
      step();
    end

    // ---------------- round-robin over three preloaded FIFOs (rr = 0 after reset)
    ob_ready_i = 1'b0;
    exp_q.delete();
    for (int m = 0; m < 2; m++) begin
      mesh_ob_valid_i = 3'b111;
      for (int c = 0; c < COLS; c++)
        mesh_ob_data_i[c*W +: W] = 32'hC000_0000 | (32'(c) << 8) | 32'(m);
      #1 check($sformatf("pre%0d_ready", m), 64'(mesh_ob_ready_o), 64'h7);
      step();
    end
    mesh_ob_valid_i = '0;
    step();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back(32'hC000_0000 | (32'(c) << 8) | 32'(m));
    ob_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check_out($sformatf("rr%0d", k));
      step();
    end
    check("rr_empty", 64'(ob_valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
